// File: rtl/transmissor_serial_paridade.sv
// Serial transmitter for a 4-bit word plus a precomputed even-parity bit.
// Frame: start(0), data LSB first, parity as received, stop(1); each bit is held DIV_BAUD clocks.
module transmissor_serial_paridade #(
    parameter int DIV_BAUD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] dado_in,
    input  logic       paridade_in,
    input  logic       valido,
    output logic       pronto,
    output logic       tx,
    output logic       ocupado,
    output logic       erro_paridade
);

    localparam int CW = $clog2(DIV_BAUD + 1);
    localparam logic [CW-1:0] BAUD_MAX = CW'(DIV_BAUD - 1);

    typedef enum logic [2:0] {
        OCIOSO,
        INICIO,
        DADOS,
        PARIDADE,
        PARADA
    } estado_t;

    estado_t       estado_q;
    logic [CW-1:0] baud_q;
    logic [1:0]    bit_q;
    logic [3:0]    dado_q;
    logic          par_q;
    logic          tx_q;
    logic          pronto_q;
    logic          ocupado_q;
    logic          erro_q;

    logic          fim_bit;
    logic [1:0]    bit_prox;

    assign fim_bit  = (baud_q == BAUD_MAX);
    assign bit_prox = bit_q + 2'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q  <= OCIOSO;
            baud_q    <= '0;
            bit_q     <= '0;
            dado_q    <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            pronto_q  <= 1'b1;
            ocupado_q <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            // The baud counter only runs while a frame is on the line and wraps at every bit boundary.
            if (estado_q != OCIOSO) begin
                baud_q <= fim_bit ? '0 : baud_q + CW'(1);
            end
            case (estado_q)
                OCIOSO: begin
                    if (valido && pronto_q) begin
                        estado_q  <= INICIO;
                        dado_q    <= dado_in;
                        par_q     <= paridade_in;
                        erro_q    <= paridade_in ^ (^dado_in);
                        bit_q     <= '0;
                        tx_q      <= 1'b0;
                        pronto_q  <= 1'b0;
                        ocupado_q <= 1'b1;
                    end
                end
                INICIO: begin
                    if (fim_bit) begin
                        estado_q <= DADOS;
                        bit_q    <= '0;
                        tx_q     <= dado_q[0];
                    end
                end
                DADOS: begin
                    if (fim_bit) begin
                        if (bit_q == 2'd3) begin
                            estado_q <= PARIDADE;
                            tx_q     <= par_q;
                        end else begin
                            bit_q <= bit_prox;
                            tx_q  <= dado_q[bit_prox];
                        end
                    end
                end
                PARIDADE: begin
                    if (fim_bit) begin
                        estado_q <= PARADA;
                        tx_q     <= 1'b1;
                    end
                end
                PARADA: begin
                    if (fim_bit) begin
                        estado_q  <= OCIOSO;
                        tx_q      <= 1'b1;
                        pronto_q  <= 1'b1;
                        ocupado_q <= 1'b0;
                    end
                end
                default: begin
                    estado_q  <= OCIOSO;
                    tx_q      <= 1'b1;
                    pronto_q  <= 1'b1;
                    ocupado_q <= 1'b0;
                end
            endcase
        end
    end

    assign pronto        = pronto_q;
    assign tx            = tx_q;
    assign ocupado       = ocupado_q;
    assign erro_paridade = erro_q;

endmodule

// File: doc/transmissor_serial_paridade.md
TRANSMISSOR_SERIAL_PARIDADE -- requirements
Module: transmissor_serial_paridade

Interface
REQ-001 The block SHALL have one parameter: DIV_BAUD, default 4, the number of clock cycles each serial bit is held; legal range 1..255.
REQ-002 The block SHALL have these ports, in this order:
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- dado_in  input  4  data word from the parity-generator stage.
- paridade_in  input  1  even-parity bit from the parity-generator stage.
- valido  input  1  dado_in/paridade_in are valid this cycle.
- pronto  output  1  block can accept a word this cycle.
- tx  output  1  serial line; idle level 1.
- ocupado  output  1  a frame is in progress.
- erro_paridade  output  1  the accepted paridade_in did not match the even parity of dado_in.
REQ-003 There SHALL be one clock and the reset SHALL be synchronous and active-high; all outputs SHALL be registered.

Function
REQ-004 Frame format SHALL be: start bit (0), dado_in[0], [1], [2], [3] (LSB first), parity bit, stop bit (1). This is 7 bits, and each bit is held exactly DIV_BAUD cycles.
REQ-005 The state machine SHALL have the states OCIOSO, INICIO, DADOS, PARIDADE and PARADA.
- OCIOSO→INICIO on accept.
- INICIO→DADOS after DIV_BAUD cycles.
- DADOS→PARIDADE after 4×DIV_BAUD cycles (a 2-bit bit index counts 0..3).
- PARIDADE→PARADA after DIV_BAUD cycles.
- PARADA→OCIOSO after DIV_BAUD cycles.
REQ-006 pronto SHALL be 1 only in OCIOSO, and ocupado SHALL equal the inverse of pronto.
REQ-007 Accept SHALL occur on the rising edge where valido=1 and pronto=1. On accept, dado_in and paridade_in SHALL be captured into internal registers.
REQ-008 Latency: if accept occurs at edge k, tx SHALL be 0 from cycle k+1 to k+DIV_BAUD, and the stop bit SHALL end at cycle k+7×DIV_BAUD.
REQ-009 After PARADA the block SHALL return to OCIOSO for at least one cycle, so that consecutive frames are spaced 7×DIV_BAUD+1 cycles apart.
REQ-010 valido while ocupado=1 SHALL be ignored (no queueing). Changes on dado_in or paridade_in during a frame SHALL NOT affect the transmitted bits.
REQ-011 The transmitted parity bit SHALL be the captured paridade_in unmodified, so that errors propagate to the receiver.
REQ-012 On accept, erro_paridade SHALL be loaded with (paridade_in XOR dado_in[0] XOR dado_in[1] XOR dado_in[2] XOR dado_in[3]). It SHALL hold that value until the next accept or reset.
REQ-013 The baud counter SHALL have width $clog2(DIV_BAUD+1), SHALL count 0..DIV_BAUD-1, and SHALL wrap to 0 at each bit boundary. With DIV_BAUD=1 every bit SHALL last exactly one cycle.
REQ-014 tx SHALL be 1 in OCIOSO, and SHALL carry no glitch or extra cycle between the stop bit and idle.

Reset
REQ-015 While reset=1, the block SHALL force these values on the next edge:
- state=OCIOSO
- tx=1
- pronto=1
- ocupado=0
- erro_paridade=0
- counters and capture registers cleared
REQ-016 If reset is asserted mid-frame, the frame SHALL be aborted, with no remaining bits sent. The block SHALL accept a new word on the first edge after reset deasserts with valido=1.
REQ-017 If reset=1 and valido=1 on the same edge, reset SHALL win and no accept SHALL occur.

Verification
REQ-018 Test: DIV_BAUD=4, dado_in=4'b1011, paridade_in=1, valido for one cycle. Expected: tx=0,1,1,0,1,1,1, each bit for 4 cycles; pronto=0 for 28 cycles; erro_paridade=0.
REQ-019 Test: DIV_BAUD=4, dado_in=4'b0000, paridade_in=1. Expected: erro_paridade=1 from the cycle after accept, and the parity bit on tx=1.
REQ-020 Test: DIV_BAUD=4, valido held at 1 with dado_in=4'b0001 then 4'b1110, and extra valido pulses during the frames. Expected: exactly two frames, starts 29 cycles apart, with the extra pulses ignored.
REQ-021 Test: DIV_BAUD=4, reset pulsed at cycle 10 of a frame. Expected: on the next cycle tx=1, pronto=1 and erro_paridade=0; a following word transmits correctly.
REQ-022 Test: DIV_BAUD=1, dado_in=4'b1010, paridade_in=0. Expected: tx=0,0,1,0,1,0,1 on consecutive cycles, then 1; pronto=1 at cycle k+8.
